// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM 1-to-8 demultiplexer: FSM states, pin and status bit positions.
package tdm_demux_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int DATA_BIT = 0;
   localparam int SYNC_BIT = 1;
   localparam int STB_BIT  = 2;

   localparam int DONE_BIT = 3;
   localparam int ERR_BIT  = 4;
   localparam int LOCK_BIT = 5;

   localparam logic [7:0] UIO_OE_VAL = 8'h3F;

endpackage

// File: rtl/tdm_edge_sync.sv
// Input conditioning for the TDM demux: optional two-flop synchronizer (TDM_DEMUX_SYNC_EN)
// followed by a strobe rising-edge detector; data and sync come from the same stage as the strobe.
module tdm_edge_sync
   import tdm_demux_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] pins_i,
   output logic       sample_o,
   output logic       data_o,
   output logic       sync_o
);

   logic [2:0] cond;
   logic       stb_prev_q;

`ifdef TDM_DEMUX_SYNC_EN
   logic [2:0] meta_q;
   logic [2:0] stable_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= '0;
         stable_q <= '0;
      end else begin
         meta_q   <= pins_i;
         stable_q <= meta_q;
      end
   end

   assign cond = stable_q;
`else
   assign cond = pins_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_prev_q <= 1'b0;
      end else begin
         stb_prev_q <= cond[STB_BIT];
      end
   end

   assign sample_o = cond[STB_BIT] & ~stb_prev_q;
   assign data_o   = cond[DATA_BIT];
   assign sync_o   = cond[SYNC_BIT];

endmodule

// File: rtl/tdm_demux_bmsce.sv
// TDM 1-to-8 demultiplexer (Tiny Tapeout user design). Define TDM_DEMUX_SYNC_EN to enable
// the two-flop input synchronizer; otherwise the pins must already be synchronous to clk.
module tdm_demux_bmsce
   import tdm_demux_pkg::*;
#(
   parameter int SLOTS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

   logic       sample;
   logic       data;
   logic       sync;

   state_t     state_q, state_d;
   logic [2:0] slot_q, slot_d;
   logic [7:0] shadow_q, shadow_d;
   logic [7:0] frame_q, frame_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       unused_ok;
   assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

   tdm_edge_sync u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .pins_i   (ui_in[2:0]),
      .sample_o (sample),
      .data_o   (data),
      .sync_o   (sync)
   );

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (sample) begin
         case (state_q)
            HUNT: begin
               if (sync) begin
                  shadow_d = {7'd0, data};
                  slot_d   = 3'd1;
                  state_d  = LOCKED;
               end
            end
            default: begin
               // A sync always restarts the frame; it is only an error when it arrives early.
               if (sync) begin
                  err_d    = (slot_q != 3'd0);
                  shadow_d = {7'd0, data};
                  slot_d   = 3'd1;
               end else if (slot_q == 3'd0) begin
                  err_d    = 1'b1;
                  state_d  = HUNT;
                  shadow_d = '0;
               end else if (slot_q == LAST_SLOT) begin
                  frame_d         = shadow_q;
                  frame_d[slot_q] = data;
                  shadow_d        = '0;
                  slot_d          = 3'd0;
                  done_d          = 1'b1;
               end else begin
                  shadow_d[slot_q] = data;
                  slot_d           = slot_q + 3'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         slot_q   <= '0;
         shadow_q <= '0;
         frame_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Slots never index past SLOTS-1, so unused channels stay 0.
   assign uo_out = frame_q;

   always_comb begin
      uio_out           = '0;
      uio_out[2:0]      = slot_q;
      uio_out[DONE_BIT] = done_q;
      uio_out[ERR_BIT]  = err_q;
      uio_out[LOCK_BIT] = (state_q == LOCKED);
   end

   assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tdm_demux_bmsce.sv
// Self-checking bench for tdm_demux_bmsce: an 8-slot and a 4-slot instance driven with
// directed and random samples and compared against a slot-rule reference model.
module tb_tdm_demux_bmsce;

`ifdef TDM_DEMUX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena = 1'b1;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] ui_a, ui_b;
   logic [7:0] uo_a, uo_b, st_a, st_b, oe_a, oe_b;

   always #5 clk = ~clk;

   tdm_demux_bmsce u_dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_a), .uio_in(uio_in),
      .uo_out(uo_a), .uio_out(st_a), .uio_oe(oe_a)
   );

   tdm_demux_bmsce #(.SLOTS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_b), .uio_in(uio_in),
      .uo_out(uo_b), .uio_out(st_b), .uio_oe(oe_b)
   );

   int checks = 0;
   int fails  = 0;

   // Reference model, one entry per instance
   int       nslots [2] = '{8, 4};
   bit       m_lock [2];
   int       m_slot [2];
   bit [7:0] m_shadow [2];
   bit [7:0] m_frame [2];
   bit       m_done [2];
   bit       m_err [2];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_lock[i] = 0; m_slot[i] = 0; m_shadow[i] = '0; m_frame[i] = '0;
         m_done[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit d, input bit s);
      m_done[i] = 0;
      m_err[i]  = 0;
      if (!m_lock[i]) begin
         if (s) begin
            m_shadow[i] = {7'd0, d}; m_slot[i] = 1; m_lock[i] = 1;
         end
      end else if (s) begin
         m_err[i]    = (m_slot[i] != 0);
         m_shadow[i] = {7'd0, d};
         m_slot[i]   = 1;
      end else if (m_slot[i] == 0) begin
         m_err[i] = 1; m_lock[i] = 0; m_shadow[i] = '0;
      end else begin
         m_shadow[i][m_slot[i]] = d;
         if (m_slot[i] == nslots[i] - 1) begin
            m_frame[i]  = m_shadow[i];
            m_shadow[i] = '0;
            m_slot[i]   = 0;
            m_done[i]   = 1;
         end else begin
            m_slot[i] = m_slot[i] + 1;
         end
      end
   endtask

   task automatic check_inst(input int i, input bit pulses, input string tag);
      logic [7:0] exp_st;
      logic [2:0] slot3;
      slot3  = 3'(m_slot[i]);
      exp_st = {2'b00, m_lock[i], pulses & m_err[i], pulses & m_done[i], slot3};
      check({tag, (i == 0) ? "_uo8" : "_uo4"}, (i == 0) ? uo_a : uo_b, m_frame[i]);
      check({tag, (i == 0) ? "_st8" : "_st4"}, (i == 0) ? st_a : st_b, exp_st);
      check({tag, (i == 0) ? "_oe8" : "_oe4"}, (i == 0) ? oe_a : oe_b, 8'h3F);
   endtask

   task automatic set_pins(input int i, input logic [7:0] v);
      if (i == 0) ui_a = v;
      else        ui_b = v;
   endtask

   // One strobe-qualified sample; checks the act latency and one-cycle pulse width.
   task automatic sample(input int i, input bit d, input bit s);
      set_pins(i, {5'd0, 1'b0, s, d});
      repeat (2) @(negedge clk);
      set_pins(i, {5'd0, 1'b1, s, d});
      for (int e = 0; e <= LAT; e++) begin
         @(posedge clk); #1;
         if (e < LAT) check_inst(i, 1'b0, "pre_act");
      end
      model_step(i, d, s);
      check_inst(i, 1'b1, "act");
      $display("sample inst=%0d data=%0d sync=%0d -> uo=%h status=%h", i, d, s,
               (i == 0) ? uo_a : uo_b, (i == 0) ? st_a : st_b);
      @(posedge clk); #1;
      check_inst(i, 1'b0, "pulse_end");
      @(negedge clk);
      set_pins(i, {5'd0, 1'b0, s, d});
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input int i, input logic [7:0] bits, input int n);
      for (int k = 0; k < n; k++) sample(i, bits[k], k == 0);
   endtask

   initial begin
      rst_n = 1'b0;
      ui_a  = '0;
      ui_b  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_inst(0, 1'b0, "reset");
      check_inst(1, 1'b0, "reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Unsynchronised samples in HUNT are ignored
      sample(0, 1'b1, 1'b0);
      sample(0, 1'b0, 1'b0);
      check("hunt_uo", uo_a, 8'h00);

      send_frame(0, 8'h4D, 8);
      check("frame_4D", uo_a, 8'h4D);
      check("locked_bit", {7'd0, st_a[5]}, 8'd1);

      send_frame(0, 8'hFF, 8);
      send_frame(0, 8'h00, 8);
      check("frame_00", uo_a, 8'h00);

      // Early sync at slot 5
      send_frame(0, 8'h15, 5);
      sample(0, 1'b1, 1'b1);
      check("early_slot", {5'd0, st_a[2:0]}, 8'd1);
      check("early_uo", uo_a, 8'h00);
      for (int k = 1; k < 8; k++) sample(0, 1'b0, 1'b0);
      check("after_early_uo", uo_a, 8'h01);

      // Missing sync at slot 0 drops lock
      sample(0, 1'b1, 1'b0);
      check("unlock_bit", {7'd0, st_a[5]}, 8'd0);

      // Random traffic on both instances, mostly well-formed frames
      for (int n = 0; n < 70; n++) begin
         int i;
         bit want, s, d;
         i    = int'($urandom_range(0, 1));
         d    = 1'($urandom_range(0, 1));
         want = !m_lock[i] || (m_slot[i] == 0);
         s    = ($urandom_range(0, 9) == 0) ? ~want : want;
         sample(i, d, s);
      end

      // 4-slot instance, clean frame
      sample(1, 1'b0, 1'b1);
      for (int k = 1; k < 4; k++) sample(1, 1'b0, 1'b0);
      send_frame(1, 8'h0B, 4);
      check("frame_0B", uo_b, 8'h0B);

      // Reset mid-frame clears everything without a clock edge
      send_frame(0, 8'h07, 3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_inst(0, 1'b0, "midreset");
      check_inst(1, 1'b0, "midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sample(0, 1'b1, 1'b0);
      sample(0, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
